// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: SOF, LEN, payload, XOR checksum; buffers good payloads and streams them out.
// Optional inter-byte timeout is built when UART_RX_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF_BYTE      = 8'hA5,
    parameter int         TIMEOUT_TICKS = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] drop_count,
    output logic       busy
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_CHK   = 2'b10;
    localparam logic [1:0] ERR_TO    = 2'b11;

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state, state_nxt;
    logic             rx_done_d, armed, vld_p0;
    logic [7:0]       byte_p0;
    logic [IDX_W-1:0] idx, rd;
    logic [7:0]       len_m1, chk;
    logic [7:0]       buf_mem [MAX_LEN];
    logic             bad_len, idx_last, rd_last, accept, chk_match, in_frame, timeout;
    logic             ok_set, err_set;
    logic [1:0]       code_set;

    // Stage p0: one event per rx_done rising edge; armed blocks a level already high at reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_done_d <= 1'b0;
            armed     <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            rx_done_d <= rx_done;
            armed     <= armed | ~rx_done;
            vld_p0    <= rx_done & ~rx_done_d & armed;
        end
    end

    always_ff @(posedge clock) begin
        byte_p0 <= rx_data;
    end

    assign bad_len   = (byte_p0 == 8'd0) || (byte_p0 > MAX_LEN_B);
    assign idx_last  = (8'(idx) == len_m1);
    assign rd_last   = (8'(rd) == len_m1);
    assign chk_match = (byte_p0 == chk);
    assign accept    = out_valid & out_ready;
    assign in_frame  = (state == LEN) || (state == PAYLOAD) || (state == CHECK);

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt;

    // A byte arriving on the terminal tick takes priority over the timeout
    assign timeout = baud_tick && !vld_p0 && in_frame &&
                     (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (vld_p0 || !in_frame || timeout) begin
            to_cnt <= '0;
        end else if (baud_tick) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_baud_tick;
    assign unused_baud_tick = baud_tick;
    assign timeout          = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT: begin
                if (vld_p0 && (byte_p0 == SOF_BYTE)) state_nxt = LEN;
            end
            LEN: begin
                if (vld_p0)       state_nxt = bad_len ? HUNT : PAYLOAD;
                else if (timeout) state_nxt = HUNT;
            end
            PAYLOAD: begin
                if (vld_p0) begin
                    if (idx_last) state_nxt = CHECK;
                end else if (timeout) begin
                    state_nxt = HUNT;
                end
            end
            CHECK: begin
                if (vld_p0)       state_nxt = chk_match ? DRAIN : HUNT;
                else if (timeout) state_nxt = HUNT;
            end
            DRAIN: begin
                if (accept && rd_last) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        out_valid = (state == DRAIN);
        out_last  = out_valid && rd_last;
        out_data  = out_valid ? buf_mem[rd] : 8'd0;
        busy      = (state != HUNT);
        ok_set    = 1'b0;
        err_set   = 1'b0;
        code_set  = 2'b00;
        if (state == LEN && vld_p0 && bad_len) begin
            err_set  = 1'b1;
            code_set = ERR_LEN;
        end else if (state == CHECK && vld_p0) begin
            ok_set   = chk_match;
            err_set  = !chk_match;
            code_set = ERR_CHK;
        end else if (timeout) begin
            err_set  = 1'b1;
            code_set = ERR_TO;
        end
    end

    // Stage p1: status pulses one cycle after the event that decided them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            frame_ok  <= ok_set;
            frame_err <= err_set;
            if (err_set) err_code <= code_set;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            rd         <= '0;
            len_m1     <= 8'd0;
            chk        <= 8'd0;
            drop_count <= 8'd0;
        end else begin
            unique case (state)
                LEN: begin
                    if (vld_p0 && !bad_len) begin
                        len_m1 <= byte_p0 - 8'd1;
                        chk    <= byte_p0;
                        idx    <= '0;
                    end
                end
                PAYLOAD: begin
                    if (vld_p0) begin
                        chk <= chk ^ byte_p0;
                        if (!idx_last) idx <= idx + 1'b1;
                    end
                end
                CHECK: begin
                    if (vld_p0 && chk_match) rd <= '0;
                end
                DRAIN: begin
                    if (accept && !rd_last) rd <= rd + 1'b1;
                    if (vld_p0) drop_count <= sat_inc(drop_count);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == PAYLOAD && vld_p0) buf_mem[idx] <= byte_p0;
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, backpressure with drops, async reset, timeout.
module tb_uart_rx_frame_ctrl;

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_done = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_ok, frame_err, busy;
    logic [1:0] err_code;
    logic [7:0] drop_count;

    uart_rx_frame_ctrl #(.MAX_LEN(16), .SOF_BYTE(8'hA5), .TIMEOUT_TICKS(200)) dut (
        .clock(clock), .reset(reset), .baud_tick(baud_tick),
        .rx_data(rx_data), .rx_done(rx_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .drop_count(drop_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0, err_cnt = 0, both_cnt = 0, vld_cyc = 0;
    logic [8:0] xq[$];

    // Sampled on the falling edge: pulses, valid cycles and accepted transfers {last,data}
    always @(negedge clock) begin
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
        if (out_valid) vld_cyc++;
        if (out_valid && out_ready) xq.push_back({out_last, out_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step(3);
        rx_done = 1'b0;
        step(2);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_ok"}, frame_ok, 0);
        check({tag, "_err"}, frame_err, 0);
        check({tag, "_code"}, err_code, 0);
        check({tag, "_drop"}, drop_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    int ok0, err0, vld0;

    initial begin
        // Reset state
        step(2);
        check_idle_outputs("rst");
        reset = 1'b0;
        step(2);

        // Good frame A5 03 11 22 33 03, streamed with out_ready high
        out_ready = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt; xq.delete();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        step(6);
        check("a_ok", ok_cnt - ok0, 1);
        check("a_err", err_cnt - err0, 0);
        check("a_n", xq.size(), 3);
        if (xq.size() == 3) begin
            check("a_b0", xq[0], {1'b0, 8'h11});
            check("a_b1", xq[1], {1'b0, 8'h22});
            check("a_b2", xq[2], {1'b1, 8'h33});
        end
        check("a_drop", drop_count, 0);
        check("a_busy", busy, 0);

        // Checksum error: A5 02 AA 55 00 (correct is FD)
        ok0 = ok_cnt; err0 = err_cnt; vld0 = vld_cyc;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'h55); send_byte(8'h00);
        step(4);
        check("b_err", err_cnt - err0, 1);
        check("b_ok", ok_cnt - ok0, 0);
        check("b_code", err_code, 2'b10);
        check("b_vld", vld_cyc - vld0, 0);
        check("b_busy", busy, 0);

        // Bad LEN 00 and 11, then a good one-byte frame
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h00);
        step(2);
        check("c_err0", err_cnt - err0, 1);
        check("c_code0", err_code, 2'b01);
        check("c_busy0", busy, 0);
        send_byte(8'hA5); send_byte(8'h11);
        step(2);
        check("c_err1", err_cnt - err0, 2);
        check("c_code1", err_code, 2'b01);
        ok0 = ok_cnt; xq.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        step(4);
        check("c_ok", ok_cnt - ok0, 1);
        check("c_n", xq.size(), 1);
        if (xq.size() == 1) check("c_b0", xq[0], {1'b1, 8'h7E});

        // Backpressure: bytes received during DRAIN are dropped, output held
        out_ready = 1'b0;
        ok0 = ok_cnt; xq.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
        check("d_ok", ok_cnt - ok0, 1);
        check("d_drop", drop_count, 5);
        check("d_valid", out_valid, 1);
        check("d_data", out_data, 8'h7E);
        check("d_last", out_last, 1);
        check("d_busy", busy, 1);
        out_ready = 1'b1;
        step(3);
        check("d_n", xq.size(), 1);
        if (xq.size() == 1) check("d_b0", xq[0], {1'b1, 8'h7E});
        check("d_busy_end", busy, 0);
        check("d_valid_end", out_valid, 0);

        // Async reset mid-PAYLOAD clears everything immediately
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        check("e_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("e_rst");
        // rx_done already high at reset release must not produce an event
        rx_data = 8'hA5;
        rx_done = 1'b1;
        step(1);
        reset = 1'b0;
        step(3);
        check("e_no_evt", busy, 0);
        rx_done = 1'b0;
        step(2);
        ok0 = ok_cnt; err0 = err_cnt; xq.delete();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3);
        send_byte(8'h3C); send_byte(8'hFD);
        step(5);
        check("e_ok", ok_cnt - ok0, 1);
        check("e_err", err_cnt - err0, 0);
        check("e_n", xq.size(), 2);
        if (xq.size() == 2) begin
            check("e_b0", xq[0], {1'b0, 8'hC3});
            check("e_b1", xq[1], {1'b1, 8'h3C});
        end

        // Inter-byte timeout after 200 baud ticks (only when the feature is built)
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        for (int i = 0; i < 199; i++) begin
            baud_tick = 1'b1; step(1);
            baud_tick = 1'b0; step(1);
        end
        step(2);
        check("f_err199", err_cnt - err0, 0);
        check("f_busy199", busy, 1);
        baud_tick = 1'b1; step(1);
        baud_tick = 1'b0; step(3);
        check("f_err", err_cnt - err0, TO_EN);
        check("f_code", err_code, (TO_EN != 0) ? 2'b11 : 2'b00);
        check("f_busy", busy, (TO_EN != 0) ? 0 : 1);

        check("excl", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into checked frames.
- Frame format: SOF byte, LEN byte, LEN payload bytes, CHK byte. CHK = XOR of LEN and all payload bytes.
- Valid payloads are buffered internally, then streamed out over a valid/ready interface with a last marker.
- Sits between the UART receiver and the command/register logic downstream.

Parameters:
- MAX_LEN, 16, maximum payload bytes; buffer depth (legal 1..255).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_TICKS, 200, inter-byte timeout in baud_tick pulses (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  baud-rate clock enable, same as the one feeding the receiver.
- rx_data  input  8  received byte; valid while rx_done is high.
- rx_done  input  1  receiver completion level; may stay high for several clock cycles.
- out_data  output  8  payload byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte.
- out_last  output  1  marks the final payload byte of the frame.
- frame_ok  output  1  one-cycle pulse: frame passed the checksum.
- frame_err  output  1  one-cycle pulse: frame rejected.
- err_code  output  2  01 bad LEN, 10 checksum mismatch, 11 timeout. Holds its last value.
- drop_count  output  8  bytes dropped while draining; saturates at 255.
- busy  output  1  high in any state other than HUNT.

Behaviour:
- Reset (async) clears everything:
  - state=HUNT; all outputs 0, including err_code and drop_count.
  - rx_done_d=0 (rx_done_d is rx_done registered by one cycle).
  - Internal indices and checksum cleared.
- Byte event = rx_done & ~rx_done_d, registered. Exactly one event per rx_done high period. If rx_done is high when reset releases, no event fires until it falls and rises again.
- HUNT:
  - Event with byte==SOF_BYTE -> LEN.
  - Any other byte is ignored silently.
- LEN:
  - Byte 0 or byte > MAX_LEN -> frame_err, err_code=01, go to HUNT.
  - Otherwise: store len, chk=byte, idx=0, go to PAYLOAD.
- PAYLOAD:
  - Each event: buf[idx]=byte, chk^=byte, idx++.
  - After the write with idx==len-1 -> CHECK.
- CHECK (next event):
  - byte==chk -> frame_ok, rd=0, go to DRAIN.
  - Otherwise -> frame_err, err_code=10, go to HUNT.
- DRAIN:
  - out_valid=1, out_data=buf[rd], out_last=(rd==len-1).
  - out_valid&out_ready advances rd.
  - When the last byte is accepted -> HUNT; out_valid falls the next cycle.
  - out_data and out_last stay stable while out_valid & ~out_ready.
- Bytes arriving in DRAIN are discarded: drop_count+1, saturating at 255. State is not affected.
- Latency: an event detected in cycle N updates state at the end of N. frame_ok, frame_err, and the first out_valid are high in cycle N+1.
- frame_ok and frame_err are never high in the same cycle.
- drop_count is cleared only by reset.
- Buffer holds MAX_LEN x 8 registers. idx and rd are wide enough for MAX_LEN-1; they never wrap within a frame.
- A new SOF seen in LEN/PAYLOAD/CHECK is treated as an ordinary data byte, not a resync.

Optional Feature:
- Macro: UART_RX_FRAME_TIMEOUT_EN.
- Defined:
  - A counter increments on baud_tick in LEN, PAYLOAD, and CHECK.
  - It clears on every byte event and on entering HUNT.
  - Reaching TIMEOUT_TICKS -> frame_err, err_code=11, go to HUNT.
  - A byte event in the same cycle as the terminal tick wins: the byte is processed and the counter clears.
- Not defined: no counter is built; err_code 11 never occurs; a partial frame waits indefinitely.

Test Plan:
- Reset asserted mid-PAYLOAD with out_ready=1 -> all outputs 0 immediately (async), busy=0. The next frame decodes normally.
- Bytes A5 03 11 22 33 03, each rx_done held high 3 cycles -> one frame_ok, then out_data 11,22,33 with out_last only on 33, drop_count=0.
- Bytes A5 02 AA 55 00 (correct CHK is FD) -> frame_err, err_code=10, out_valid never asserted.
- A5 00, then A5 11 with MAX_LEN=16 -> two frame_err pulses, err_code=01 each time. A following valid frame A5 01 7E 7F is accepted.
- Valid frame A5 01 7E 7F with out_ready held low; 5 more bytes received -> drop_count=5, out_data=7E stable. Then out_ready=1 -> one transfer, out_last=1, busy falls.
- With UART_RX_FRAME_TIMEOUT_EN: A5 02 10, then 200 baud_ticks with no rx_done -> frame_err, err_code=11 after the 200th tick. Without the macro -> no error, busy stays 1.
